// File: rtl/bp_fe_icache_mem_responder.sv
// Memory endpoint for the I$ miss engine: queues memory commands and answers them from a block store.
// Latency: response valid latency_p+1 cycles after a command is accepted into an empty, idle responder.
// Backpressure: mem_cmd_ready_o drops when the command queue is full; a response is held until mem_resp_yumi_i.
//
// Ports:
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   mem_cmd_*             command stream (v/ready): op, byte address, size, payload, write data
//   mem_resp_*            response stream (v/yumi): echoed op/addr/size/payload plus read data

// Small generic FIFO used for the command queue.
// Latency: data written on one cycle is visible at data_o on the next cycle.
// Backpressure: ready_o is low when all els_p entries are occupied.
module bp_fe_icache_mem_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_r;
    logic [ptr_w_lp-1:0] rd_ptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                enq;
    logic                deq;

    // ready depends only on the registered count, so a same-cycle dequeue
    // never opens a slot for an enqueue while full.
    assign ready_o = (count_r != cnt_w_lp'(els_p));
    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rd_ptr_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_r + 1'b1;
            end
            if (deq) begin
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_r + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module bp_fe_icache_mem_responder #(
    parameter int paddr_width_p   = 40,
    parameter int block_width_p   = 512,
    parameter int payload_width_p = 16,
    parameter int mem_els_p       = 1024,
    parameter int latency_p       = 4,
    parameter int cmd_els_p       = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       mem_cmd_v_i,
    output logic                       mem_cmd_ready_o,
    input  logic [1:0]                 mem_cmd_op_i,
    input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
    input  logic [2:0]                 mem_cmd_size_i,
    input  logic [payload_width_p-1:0] mem_cmd_payload_i,
    input  logic [block_width_p-1:0]   mem_cmd_data_i,

    output logic                       mem_resp_v_o,
    input  logic                       mem_resp_yumi_i,
    output logic [1:0]                 mem_resp_op_o,
    output logic [paddr_width_p-1:0]   mem_resp_addr_o,
    output logic [2:0]                 mem_resp_size_o,
    output logic [payload_width_p-1:0] mem_resp_payload_o,
    output logic [block_width_p-1:0]   mem_resp_data_o
);
    localparam int block_bytes_lp = block_width_p / 8;
    localparam int offset_w_lp    = $clog2(block_bytes_lp);
    localparam int index_w_lp     = $clog2(mem_els_p);
    localparam int cnt_w_lp       = (latency_p > 1) ? $clog2(latency_p) : 1;

    localparam logic [1:0] op_block_rd = 2'd0;
    localparam logic [1:0] op_block_wr = 2'd1;
    localparam logic [1:0] op_uc_rd    = 2'd2;
    localparam logic [1:0] op_uc_wr    = 2'd3;

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_wait = 2'd1;
    localparam logic [1:0] st_resp = 2'd2;

    typedef struct packed {
        logic [1:0]                 op;
        logic [paddr_width_p-1:0]   addr;
        logic [2:0]                 size;
        logic [payload_width_p-1:0] payload;
        logic [block_width_p-1:0]   data;
    } mem_cmd_t;

    mem_cmd_t                 cmd_dat;
    mem_cmd_t                 q_dat;
    logic                     q_vld;
    logic                     q_rdy;
    logic                     q_yumi;

    logic [1:0]               state_r;
    logic [cnt_w_lp-1:0]      cnt_r;
    mem_cmd_t                 active_r;
    logic [block_width_p-1:0] resp_data_r;

    logic [block_width_p-1:0] store_r [mem_els_p];

    logic [index_w_lp-1:0]    index;
    logic [offset_w_lp-1:0]   offset;
    logic [offset_w_lp-1:0]   size_mask;
    logic [offset_w_lp-1:0]   aligned_off;
    int                       n_bytes;
    logic [block_width_p-1:0] old_block;
    logic [block_width_p-1:0] uc_rd_data;
    logic [block_width_p-1:0] uc_wr_block;
    logic [block_width_p-1:0] rd_data;
    logic [block_width_p-1:0] wr_block;
    logic                     access;
    logic                     store_we;

    assign cmd_dat = '{op:      mem_cmd_op_i,
                       addr:    mem_cmd_addr_i,
                       size:    mem_cmd_size_i,
                       payload: mem_cmd_payload_i,
                       data:    mem_cmd_data_i};

    bp_fe_icache_mem_fifo #(
        .width_p ($bits(mem_cmd_t)),
        .els_p   (cmd_els_p)
    ) cmd_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (mem_cmd_v_i),
        .ready_o   (q_rdy),
        .data_i    (cmd_dat),
        .v_o       (q_vld),
        .yumi_i    (q_yumi),
        .data_o    (q_dat)
    );

    // Gate with reset so ready reads 0 while reset is held, not just after.
    assign mem_cmd_ready_o = reset_n_i & q_rdy;

    // Head is consumed from IDLE, or straight out of RESP on yumi so that
    // back-to-back commands skip the IDLE cycle.
    assign q_yumi = q_vld & ((state_r == st_idle) |
                             ((state_r == st_resp) & mem_resp_yumi_i));

    // Address decode: upper address bits are ignored, so the store wraps.
    assign index       = active_r.addr[offset_w_lp +: index_w_lp];
    assign offset      = active_r.addr[offset_w_lp-1:0];
    assign n_bytes     = 1 << active_r.size;
    assign size_mask   = offset_w_lp'(n_bytes - 1);
    assign aligned_off = offset & ~size_mask;

    always_comb begin
        old_block   = store_r[index];
        uc_wr_block = old_block;
        uc_rd_data  = '0;
        for (int i = 0; i < block_bytes_lp; i++) begin
            // Merge right-justified write bytes into the aligned window.
            if ((i >= int'(aligned_off)) && (i < int'(aligned_off) + n_bytes)) begin
                uc_wr_block[i*8 +: 8] = active_r.data[(i - int'(aligned_off))*8 +: 8];
            end
            // Replicate the aligned field across the whole response.
            uc_rd_data[i*8 +: 8] = old_block[(int'(aligned_off) + (i & (n_bytes - 1)))*8 +: 8];
        end
    end

    always_comb begin
        rd_data  = '0;
        wr_block = old_block;
        case (active_r.op)
            op_block_rd: rd_data  = old_block;
            op_block_wr: wr_block = active_r.data;
            op_uc_rd:    rd_data  = uc_rd_data;
            op_uc_wr:    wr_block = uc_wr_block;
            default:     rd_data  = '0;
        endcase
    end

    // The single store access happens on the WAIT -> RESP transition.
    assign access   = (state_r == st_wait) && (cnt_r == '0);
    assign store_we = access && active_r.op[0];

    always_ff @(posedge clk_i) begin
        if (store_we) begin
            store_r[index] <= wr_block;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= st_idle;
            cnt_r       <= '0;
            active_r    <= '0;
            resp_data_r <= '0;
        end else begin
            case (state_r)
                st_idle: begin
                    if (q_vld) begin
                        active_r <= q_dat;
                        cnt_r    <= cnt_w_lp'(latency_p - 1);
                        state_r  <= st_wait;
                    end
                end
                st_wait: begin
                    if (access) begin
                        resp_data_r <= rd_data;
                        state_r     <= st_resp;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                st_resp: begin
                    if (mem_resp_yumi_i) begin
                        if (q_vld) begin
                            active_r <= q_dat;
                            cnt_r    <= cnt_w_lp'(latency_p - 1);
                            state_r  <= st_wait;
                        end else begin
                            state_r <= st_idle;
                        end
                    end
                end
                default: state_r <= st_idle;
            endcase
        end
    end

    assign mem_resp_v_o       = (state_r == st_resp);
    assign mem_resp_op_o      = active_r.op;
    assign mem_resp_addr_o    = active_r.addr;
    assign mem_resp_size_o    = active_r.size;
    assign mem_resp_payload_o = active_r.payload;
    assign mem_resp_data_o    = resp_data_r;
endmodule

// File: tb/tb_bp_fe_icache_mem_responder.sv
// Directed bench for bp_fe_icache_mem_responder: one instance with latency 4 / depth 2,
// one with latency 1, checked with immediate assertions against hand-computed values.
module tb_bp_fe_icache_mem_responder;
    localparam int lat0 = 4;
    localparam int lat1 = 1;

    logic         clk;
    logic         rst_n;
    logic         cmd_v       [2];
    logic         cmd_ready   [2];
    logic [1:0]   cmd_op      [2];
    logic [39:0]  cmd_addr    [2];
    logic [2:0]   cmd_size    [2];
    logic [15:0]  cmd_payload [2];
    logic [511:0] cmd_data    [2];
    logic         resp_v      [2];
    logic         yumi        [2];
    logic [1:0]   resp_op     [2];
    logic [39:0]  resp_addr   [2];
    logic [2:0]   resp_size   [2];
    logic [15:0]  resp_payload[2];
    logic [511:0] resp_data   [2];

    int checks   = 0;
    int failures = 0;

    bp_fe_icache_mem_responder #(.latency_p(lat0)) dut0 (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_v_i(cmd_v[0]), .mem_cmd_ready_o(cmd_ready[0]), .mem_cmd_op_i(cmd_op[0]),
        .mem_cmd_addr_i(cmd_addr[0]), .mem_cmd_size_i(cmd_size[0]),
        .mem_cmd_payload_i(cmd_payload[0]), .mem_cmd_data_i(cmd_data[0]),
        .mem_resp_v_o(resp_v[0]), .mem_resp_yumi_i(yumi[0]), .mem_resp_op_o(resp_op[0]),
        .mem_resp_addr_o(resp_addr[0]), .mem_resp_size_o(resp_size[0]),
        .mem_resp_payload_o(resp_payload[0]), .mem_resp_data_o(resp_data[0])
    );

    bp_fe_icache_mem_responder #(.latency_p(lat1)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_v_i(cmd_v[1]), .mem_cmd_ready_o(cmd_ready[1]), .mem_cmd_op_i(cmd_op[1]),
        .mem_cmd_addr_i(cmd_addr[1]), .mem_cmd_size_i(cmd_size[1]),
        .mem_cmd_payload_i(cmd_payload[1]), .mem_cmd_data_i(cmd_data[1]),
        .mem_resp_v_o(resp_v[1]), .mem_resp_yumi_i(yumi[1]), .mem_resp_op_o(resp_op[1]),
        .mem_resp_addr_o(resp_addr[1]), .mem_resp_size_o(resp_size[1]),
        .mem_resp_payload_o(resp_payload[1]), .mem_resp_data_o(resp_data[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until it transfers on a clock edge.
    task automatic send(input int d, input logic [1:0] op, input logic [39:0] addr,
                        input logic [2:0] size, input logic [15:0] pl, input logic [511:0] dat);
        int n;
        cmd_v[d] = 1'b1; cmd_op[d] = op; cmd_addr[d] = addr;
        cmd_size[d] = size; cmd_payload[d] = pl; cmd_data[d] = dat;
        n = 0;
        while (!cmd_ready[d] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("send_ready", {511'd0, cmd_ready[d]}, 512'd1);
        tick();
        cmd_v[d] = 1'b0;
    endtask

    // Wait for a response, check latency and every field, then consume it.
    task automatic expect_resp(input int d, input string tag, input logic [1:0] op,
                               input logic [39:0] addr, input logic [2:0] size,
                               input logic [15:0] pl, input logic [511:0] dat, input int exp_cyc);
        int cyc;
        cyc = 0;
        while (!resp_v[d] && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_v"},       {511'd0, resp_v[d]},  512'd1);
        chk({tag, "_lat"},     512'(cyc),            512'(exp_cyc));
        chk({tag, "_op"},      {510'd0, resp_op[d]}, {510'd0, op});
        chk({tag, "_addr"},    512'(resp_addr[d]),   512'(addr));
        chk({tag, "_size"},    512'(resp_size[d]),   512'(size));
        chk({tag, "_payload"}, 512'(resp_payload[d]), 512'(pl));
        chk({tag, "_data"},    resp_data[d],         dat);
        yumi[d] = 1'b1;
        tick();
        yumi[d] = 1'b0;
    endtask

    logic [511:0] pat_a, pat_b, pat_c, pat_d, tmp;
    logic         seen;

    initial begin
        for (int i = 0; i < 64; i++) pat_a[i*8 +: 8] = 8'hA0 ^ 8'(i);
        pat_b = pat_a;
        pat_b[32 +: 32] = 32'hDEADBEEF;
        pat_c = {8{64'h0123_4567_89AB_CDEF}};
        pat_d = {16{32'hCAFE_0001}};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmd_v[d] = 1'b0; cmd_op[d] = '0; cmd_addr[d] = '0; cmd_size[d] = '0;
            cmd_payload[d] = '0; cmd_data[d] = '0; yumi[d] = 1'b0;
        end

        // Reset state
        #2;
        chk("rst_ready0",   {511'd0, cmd_ready[0]}, 512'd0);
        chk("rst_ready1",   {511'd0, cmd_ready[1]}, 512'd0);
        chk("rst_resp_v0",  {511'd0, resp_v[0]},    512'd0);
        chk("rst_op0",      {510'd0, resp_op[0]},   512'd0);
        chk("rst_addr0",    512'(resp_addr[0]),     512'd0);
        chk("rst_payload0", 512'(resp_payload[0]),  512'd0);
        chk("rst_data0",    resp_data[0],           512'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready0", {511'd0, cmd_ready[0]}, 512'd1);

        // Block write then block read
        send(0, 2'd1, 40'h80_0000_0040, 3'd6, 16'h1234, pat_a);
        expect_resp(0, "bwr", 2'd1, 40'h80_0000_0040, 3'd6, 16'h1234, 512'd0, lat0 + 1);
        send(0, 2'd0, 40'h80_0000_0040, 3'd6, 16'h2222, 512'd0);
        expect_resp(0, "brd", 2'd0, 40'h80_0000_0040, 3'd6, 16'h2222, pat_a, lat0 + 1);

        // Uncached write of a word at offset 4, then uncached reads of several sizes
        send(0, 2'd3, 40'h80_0000_0044, 3'd2, 16'h3333, 512'hDEADBEEF);
        expect_resp(0, "ucwr", 2'd3, 40'h80_0000_0044, 3'd2, 16'h3333, 512'd0, lat0 + 1);
        send(0, 2'd2, 40'h80_0000_0044, 3'd2, 16'h4444, 512'd0);
        expect_resp(0, "ucrd4", 2'd2, 40'h80_0000_0044, 3'd2, 16'h4444, {16{32'hDEADBEEF}}, lat0 + 1);
        send(0, 2'd2, 40'h80_0000_0045, 3'd0, 16'h4445, 512'd0);
        expect_resp(0, "ucrd1", 2'd2, 40'h80_0000_0045, 3'd0, 16'h4445, {64{8'hBE}}, lat0 + 1);
        tmp = {8{32'hDEADBEEF, pat_a[31:0]}};
        send(0, 2'd2, 40'h80_0000_0047, 3'd3, 16'h4446, 512'd0);
        expect_resp(0, "ucrd8", 2'd2, 40'h80_0000_0047, 3'd3, 16'h4446, tmp, lat0 + 1);
        send(0, 2'd2, 40'h80_0000_007F, 3'd6, 16'h4447, 512'd0);
        expect_resp(0, "ucrd64", 2'd2, 40'h80_0000_007F, 3'd6, 16'h4447, pat_b, lat0 + 1);
        send(0, 2'd0, 40'h80_0000_0040, 3'd6, 16'h5555, 512'd0);
        expect_resp(0, "brd_merge", 2'd0, 40'h80_0000_0040, 3'd6, 16'h5555, pat_b, lat0 + 1);

        // Queue fill with the consumer stalled, then in-order drain
        send(0, 2'd0, 40'h80_0000_0040, 3'd6, 16'h0A01, 512'd0);
        send(0, 2'd0, 40'h80_0000_0040, 3'd6, 16'h0A02, 512'd0);
        send(0, 2'd0, 40'h80_0000_0040, 3'd6, 16'h0A03, 512'd0);
        chk("q_full_ready", {511'd0, cmd_ready[0]}, 512'd0);
        begin
            int cyc;
            cyc = 0;
            while (!resp_v[0] && cyc < 100) begin
                tick();
                cyc++;
            end
            chk("q_first_lat", 512'(cyc), 512'(lat0 - 1));
        end
        tick();
        tick();
        chk("q_hold_v",       {511'd0, resp_v[0]},    512'd1);
        chk("q_hold_payload", 512'(resp_payload[0]),  512'h0A01);
        chk("q_hold_ready",   {511'd0, cmd_ready[0]}, 512'd0);
        expect_resp(0, "q1", 2'd0, 40'h80_0000_0040, 3'd6, 16'h0A01, pat_b, 0);
        chk("q_ready_after_yumi", {511'd0, cmd_ready[0]}, 512'd1);
        expect_resp(0, "q2", 2'd0, 40'h80_0000_0040, 3'd6, 16'h0A02, pat_b, lat0);
        expect_resp(0, "q3", 2'd0, 40'h80_0000_0040, 3'd6, 16'h0A03, pat_b, lat0);

        // Address wrap: index 0 aliases with index mem_els_p
        send(0, 2'd1, 40'h80_0000_0000, 3'd6, 16'h6601, pat_c);
        expect_resp(0, "wrap_wr", 2'd1, 40'h80_0000_0000, 3'd6, 16'h6601, 512'd0, lat0 + 1);
        send(0, 2'd0, 40'h80_0001_0000, 3'd6, 16'h6602, 512'd0);
        expect_resp(0, "wrap_rd", 2'd0, 40'h80_0001_0000, 3'd6, 16'h6602, pat_c, lat0 + 1);

        // Reset during WAIT with one command queued
        send(0, 2'd0, 40'h80_0000_0040, 3'd6, 16'h0B01, 512'd0);
        send(0, 2'd0, 40'h80_0000_0040, 3'd6, 16'h0B02, 512'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready",   {511'd0, cmd_ready[0]}, 512'd0);
        chk("mid_rst_v",       {511'd0, resp_v[0]},    512'd0);
        chk("mid_rst_payload", 512'(resp_payload[0]),  512'd0);
        chk("mid_rst_addr",    512'(resp_addr[0]),     512'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_release_ready", {511'd0, cmd_ready[0]}, 512'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (resp_v[0]) seen = 1'b1;
            tick();
        end
        chk("mid_rst_no_stale", {511'd0, seen}, 512'd0);
        send(0, 2'd0, 40'h80_0000_0040, 3'd6, 16'h0C01, 512'd0);
        expect_resp(0, "post_rst_rd", 2'd0, 40'h80_0000_0040, 3'd6, 16'h0C01, pat_b, lat0 + 1);

        // latency_p = 1 instance: t+2 latency and one response every 2 cycles
        send(1, 2'd1, 40'h80_0000_0080, 3'd6, 16'h7701, pat_d);
        expect_resp(1, "l1_wr", 2'd1, 40'h80_0000_0080, 3'd6, 16'h7701, 512'd0, lat1 + 1);
        send(1, 2'd0, 40'h80_0000_0080, 3'd6, 16'h7702, 512'd0);
        send(1, 2'd2, 40'h80_0000_0084, 3'd2, 16'h7703, 512'd0);
        expect_resp(1, "l1_rd1", 2'd0, 40'h80_0000_0080, 3'd6, 16'h7702, pat_d, 1);
        expect_resp(1, "l1_rd2", 2'd2, 40'h80_0000_0084, 3'd2, 16'h7703, {16{32'hCAFE_0001}}, lat1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
